// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens, alignment FSM states, widths.
package tmds_pkg;

  localparam logic [9:0] TOK_C00 = 10'h354;
  localparam logic [9:0] TOK_C01 = 10'h0AB;
  localparam logic [9:0] TOK_C10 = 10'h154;
  localparam logic [9:0] TOK_C11 = 10'h2AB;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int             OFS_W   = 4;
  localparam logic [OFS_W-1:0] OFS_MAX = 4'd9;
  localparam int             CNT_W   = 12;

  // Returns {is_ctrl, c1, c0}; non-token symbols map to 3'b000.
  function automatic logic [2:0] ctrl_lookup(input logic [9:0] s);
    case (s)
      TOK_C00: ctrl_lookup = 3'b100;
      TOK_C01: ctrl_lookup = 3'b101;
      TOK_C10: ctrl_lookup = 3'b110;
      TOK_C11: ctrl_lookup = 3'b111;
      default: ctrl_lookup = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS 10b symbol decode: control-token detect plus 8b data recovery.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym_i,
  output logic       is_ctrl_o,
  output logic [1:0] c_o,
  output logic [7:0] data_o
);

  logic [7:0] t;

  always_comb begin
    {is_ctrl_o, c_o} = ctrl_lookup(sym_i);
    t      = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
    data_o = '0;
    data_o[0] = t[0];
    // bit 8 selects XOR vs XNOR chaining used by the encoder
    for (int i = 1; i < 8; i++)
      data_o[i] = sym_i[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
  end

endmodule

// File: rtl/tmds_decoder.sv
// One-channel TMDS receiver: bit-slip alignment from control-token runs, then decode.
// Optional lock-loss counter on err_cnt enabled by TMDS_DECODER_ERRCNT_EN.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 1024
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [9:0]       din,
  output logic [7:0]       data_out,
  output logic             de,
  output logic             c0,
  output logic             c1,
  output logic             locked,
  output logic [OFS_W-1:0] offset,
  output logic [7:0]       err_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [9:0]       prev_q, sym_q, window;
  logic [19:0]      cat;
  state_e           state_q, state_d;
  logic [OFS_W-1:0] offset_q, offset_d;
  logic [CNT_W-1:0] run_q, run_d, tmo_q, tmo_d, loss_q, loss_d;
  logic [1:0]       flush_q, flush_d;
  logic [7:0]       data_q;
  logic             de_q;
  logic [1:0]       c_q;

  logic             is_ctrl;
  logic [1:0]       ctrl_c;
  logic [7:0]       dec_data;

  // Bits of the current word sit above the previous word so offset walks forward in wire order.
  assign cat    = {din, prev_q};
  assign window = cat[{1'b0, offset_q} +: 10];

  tmds_symbol_decode u_dec (
    .sym_i     (sym_q),
    .is_ctrl_o (is_ctrl),
    .c_o       (ctrl_c),
    .data_o    (dec_data)
  );

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    run_d    = run_q;
    tmo_d    = tmo_q;
    loss_d   = loss_q;
    flush_d  = flush_q;
    if (state_q == ST_SEARCH) begin
      tmo_d = tmo_q + CNT_ONE;
      if (flush_q != 2'd0) flush_d = flush_q - 2'd1;
      else if (is_ctrl)    run_d   = run_q + CNT_ONE;
      else                 run_d   = '0;
      if (flush_q == 2'd0 && is_ctrl && run_q == CNT_W'(CTRL_RUN - 1)) begin
        state_d = ST_LOCKED;
        run_d   = '0;
        tmo_d   = '0;
        loss_d  = '0;
      end else if (tmo_q == CNT_W'(SEARCH_TIMEOUT - 1)) begin
        offset_d = (offset_q == OFS_MAX) ? '0 : offset_q + 4'd1;
        run_d    = '0;
        tmo_d    = '0;
        // sym still carries the old alignment for two cycles
        flush_d  = 2'd2;
      end
    end else begin
      if (is_ctrl) begin
        loss_d = '0;
      end else if (loss_q == CNT_W'(LOSS_TIMEOUT - 1)) begin
        state_d = ST_SEARCH;
        loss_d  = '0;
        run_d   = '0;
        tmo_d   = '0;
      end else begin
        loss_d = loss_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      sym_q    <= '0;
      state_q  <= ST_SEARCH;
      offset_q <= '0;
      run_q    <= '0;
      tmo_q    <= '0;
      loss_q   <= '0;
      flush_q  <= '0;
      data_q   <= '0;
      de_q     <= 1'b0;
      c_q      <= '0;
    end else begin
      prev_q   <= din;
      sym_q    <= window;
      state_q  <= state_d;
      offset_q <= offset_d;
      run_q    <= run_d;
      tmo_q    <= tmo_d;
      loss_q   <= loss_d;
      flush_q  <= flush_d;
      if (state_q == ST_LOCKED) begin
        if (is_ctrl) begin
          de_q   <= 1'b0;
          data_q <= '0;
          c_q    <= ctrl_c;
        end else begin
          de_q   <= 1'b1;
          data_q <= dec_data;
        end
      end else begin
        de_q   <= 1'b0;
        data_q <= '0;
        c_q    <= '0;
      end
    end
  end

`ifdef TMDS_DECODER_ERRCNT_EN
  logic [7:0] err_q;
  always_ff @(posedge pclk or posedge rst) begin
    if (rst)
      err_q <= '0;
    else if (state_q == ST_LOCKED && state_d == ST_SEARCH && err_q != 8'hFF)
      err_q <= err_q + 8'd1;
  end
  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

  assign data_out = data_q;
  assign de       = de_q;
  assign c0       = c_q[0];
  assign c1       = c_q[1];
  assign locked   = (state_q == ST_LOCKED);
  assign offset   = offset_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder with short search/loss timeouts.
module tb_tmds_decoder;

  logic       pclk = 1'b0;
  logic       rst;
  logic [9:0] din;
  logic [7:0] data_out;
  logic       de, c0, c1, locked;
  logic [3:0] offset;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;
  int exp_err = 0;

  localparam logic [9:0] T354    = 10'h354;
  localparam logic [9:0] T0AB    = 10'h0AB;
  localparam logic [9:0] T154    = 10'h154;
  localparam logic [9:0] T2AB    = 10'h2AB;
  localparam logic [9:0] D10F    = 10'h10F;
  localparam logic [9:0] T354_R3 = 10'h2A6;
  localparam logic [9:0] D10F_R3 = 10'h07A;

  always #5 pclk = ~pclk;

  tmds_decoder #(.CTRL_RUN(8), .SEARCH_TIMEOUT(16), .LOSS_TIMEOUT(32)) dut (
    .pclk(pclk), .rst(rst), .din(din), .data_out(data_out), .de(de),
    .c0(c0), .c1(c1), .locked(locked), .offset(offset), .err_cnt(err_cnt)
  );

  task automatic tick(input int n);
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = '0;
    #12;
    checks++; if ({locked, de, c0, c1} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {locked, de, c0, c1}); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", data_out); end
    checks++; if (offset !== 4'd0) begin errors++; $display("FAIL reset_offset: got %0d exp 0", offset); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_errcnt: got %0d exp 0", err_cnt); end
  endtask

  task automatic test_aligned_lock();
    int cyc;
    do_reset();
    din = T354; cyc = 0;
    while (!locked && cyc < 20) begin tick(1); cyc++; end
    checks++; if (cyc !== 10) begin errors++; $display("FAIL lock_cycle: got %0d exp 10", cyc); end
    tick(2);
    checks++; if ({c1, c0, de, data_out} !== 11'h0) begin errors++; $display("FAIL lock_c00: got c1c0=%b%b de=%b d=%h exp 00 0 00", c1, c0, de, data_out); end
    din = T0AB; tick(3);
    checks++; if ({c1, c0, de} !== 3'b010) begin errors++; $display("FAIL tok_0ab: got c1c0de=%b exp 010", {c1, c0, de}); end
    din = T154; tick(3);
    checks++; if ({c1, c0, de} !== 3'b100) begin errors++; $display("FAIL tok_154: got c1c0de=%b exp 100", {c1, c0, de}); end
    din = T2AB; tick(3);
    checks++; if ({c1, c0, de} !== 3'b110) begin errors++; $display("FAIL tok_2ab: got c1c0de=%b exp 110", {c1, c0, de}); end
    din = T0AB; tick(3);
    checks++; if ({c1, c0, locked} !== 3'b011) begin errors++; $display("FAIL tok_0ab_again: got c1c0lk=%b exp 011", {c1, c0, locked}); end
  endtask

  task automatic test_data_decode();
    din = 10'h100; tick(3);
    checks++; if ({de, data_out} !== 9'h100) begin errors++; $display("FAIL dec_100: got de=%b d=%h exp 1 00", de, data_out); end
    checks++; if ({c1, c0} !== 2'b01) begin errors++; $display("FAIL c_hold: got %b%b exp 01", c1, c0); end
    din = 10'h2FF; tick(3);
    checks++; if ({de, data_out} !== 9'h1FE) begin errors++; $display("FAIL dec_2ff: got de=%b d=%h exp 1 fe", de, data_out); end
    din = D10F; tick(3);
    checks++; if ({de, data_out} !== 9'h111) begin errors++; $display("FAIL dec_10f: got de=%b d=%h exp 1 11", de, data_out); end
    checks++; if ({c1, c0} !== 2'b01) begin errors++; $display("FAIL c_hold2: got %b%b exp 01", c1, c0); end
    din = T354; tick(3);
    checks++; if ({c1, c0, de, data_out} !== 11'h0) begin errors++; $display("FAIL back_to_c00: got c1c0=%b%b de=%b d=%h", c1, c0, de, data_out); end
  endtask

  task automatic test_loss();
    int cyc;
    din = D10F; cyc = 0;
    while (locked && cyc < 50) begin tick(1); cyc++; end
    checks++; if (cyc !== 34) begin errors++; $display("FAIL loss_cycle: got %0d exp 34", cyc); end
    checks++; if (offset !== 4'd0) begin errors++; $display("FAIL loss_offset: got %0d exp 0", offset); end
`ifdef TMDS_DECODER_ERRCNT_EN
    exp_err = 1;
`endif
    checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL loss_errcnt: got %0d exp %0d", err_cnt, exp_err); end
    din = T354; cyc = 0;
    while (!locked && cyc < 20) begin tick(1); cyc++; end
    checks++; if (cyc !== 10) begin errors++; $display("FAIL relock_cycle: got %0d exp 10", cyc); end
    tick(3);
  endtask

  task automatic test_loss_cancel();
    int cyc;
    logic l40;
    cyc = 0; l40 = 1'b0;
    while (locked && cyc < 80) begin
      din = (cyc == 31) ? T354 : D10F;
      tick(1); cyc++;
      if (cyc == 40) l40 = locked;
    end
    checks++; if (l40 !== 1'b1) begin errors++; $display("FAIL cancel_held: got %b exp 1", l40); end
    checks++; if (cyc !== 66) begin errors++; $display("FAIL cancel_restart: got %0d exp 66", cyc); end
`ifdef TMDS_DECODER_ERRCNT_EN
    exp_err = 2;
`endif
    checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL cancel_errcnt: got %0d exp %0d", err_cnt, exp_err); end
  endtask

  task automatic test_misalign();
    int cyc, nchg;
    int chg[3];
    logic [3:0] last;
    do_reset();
    din = T354_R3; cyc = 0; nchg = 0; last = offset;
    chg[0] = -1; chg[1] = -1; chg[2] = -1;
    while (!locked && cyc < 80) begin
      tick(1); cyc++;
      if (offset != last && nchg < 3) begin chg[nchg] = cyc; nchg++; end
      last = offset;
    end
    checks++; if (chg[0] !== 16 || chg[1] !== 32 || chg[2] !== 48) begin errors++; $display("FAIL slip_steps: got %0d %0d %0d exp 16 32 48", chg[0], chg[1], chg[2]); end
    checks++; if (cyc !== 58) begin errors++; $display("FAIL slip_lock: got %0d exp 58", cyc); end
    tick(20);
    checks++; if ({locked, offset} !== 5'h13) begin errors++; $display("FAIL slip_hold: got lk=%b ofs=%0d exp 1 3", locked, offset); end
    din = D10F_R3; tick(3);
    checks++; if ({de, data_out} !== 9'h111) begin errors++; $display("FAIL slip_data: got de=%b d=%h exp 1 11", de, data_out); end
    #2 rst = 1'b1; #1;
    checks++; if ({locked, de, data_out, offset} !== 14'h0) begin errors++; $display("FAIL async_rst_locked: got lk=%b de=%b d=%h ofs=%0d", locked, de, data_out, offset); end
  endtask

  task automatic test_async_reset();
    do_reset();
    din = D10F;
    tick(80);
    checks++; if ({locked, offset} !== 5'h05) begin errors++; $display("FAIL search_ofs5: got lk=%b ofs=%0d exp 0 5", locked, offset); end
    #2 rst = 1'b1; #1;
    checks++; if ({locked, de, data_out, offset} !== 14'h0) begin errors++; $display("FAIL async_rst_ofs5: got lk=%b de=%b d=%h ofs=%0d", locked, de, data_out, offset); end
    do_reset();
    tick(159);
    checks++; if (offset !== 4'd9) begin errors++; $display("FAIL ofs_max: got %0d exp 9", offset); end
    tick(1);
    checks++; if (offset !== 4'd0) begin errors++; $display("FAIL ofs_wrap: got %0d exp 0", offset); end
  endtask

  initial begin
    test_reset();
    test_aligned_lock();
    test_data_decode();
    test_loss();
    test_loss_cancel();
    test_misalign();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
